// File: rtl/decode_stage.sv
// decode_stage: buffered RV32I decode (IFQ FIFO -> registered decode bundle -> EX) with flush and HALT on illegal.
// Defining DECODE_MULDIV_EN makes RV32M OP encodings legal and drives DU_muldiv.
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IFQ_valid,
    output logic                    IFQ_ready,
    input  logic [31:0]             IFQ_instr,
    input  logic [PC_W-1:0]         IFQ_pc,
    input  logic                    DU_flush,
    input  logic                    EX_ready,
    output logic                    DU_valid,
    output logic [PC_W-1:0]         DU_pc,
    output logic [4:0]              DU_rs1,
    output logic [4:0]              DU_rs2,
    output logic [4:0]              DU_rd,
    output logic [31:0]             DU_imm,
    output logic [2:0]              DU_aluop,
    output logic                    DU_sra_sub,
    output logic                    DU_alusrc_imm,
    output logic                    DU_memread,
    output logic                    DU_memwrite,
    output logic                    DU_br,
    output logic                    DU_jal,
    output logic                    DU_jalr,
    output logic                    DU_lui,
    output logic                    DU_auipc,
    output logic                    DU_regwrite,
    output logic                    DU_illegal,
    output logic                    DU_muldiv,
    output logic                    DU_halted,
    output logic [$clog2(DEPTH):0]  DU_count
);
    localparam int AW = $clog2(DEPTH);
`ifdef DECODE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nx;
    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, load;
    logic [31:0]     i, imm, imm_i;
    logic [6:0]      op, f7;
    logic [2:0]      f3;
    logic ok, sra_sub, alusrc_imm, memread, memwrite, br, jal, jalr, lui, auipc, regwrite, muldiv;
    assign IFQ_ready = DU_count != (AW+1)'(DEPTH);
    assign push = IFQ_valid & IFQ_ready & ~DU_flush;
    assign load = (state == RUN) & (DU_count != '0) & (~DU_valid | EX_ready) & ~DU_flush;
    assign i = instr_mem[rd_ptr];
    assign op = i[6:0];
    assign f3 = i[14:12];
    assign f7 = i[31:25];
    assign imm_i = {{21{i[31]}}, i[30:20]};
    always_comb begin
        ok = 1'b0;
        sra_sub = 1'b0;
        alusrc_imm = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        br = 1'b0;
        jal = 1'b0;
        jalr = 1'b0;
        lui = 1'b0;
        auipc = 1'b0;
        regwrite = 1'b0;
        muldiv = 1'b0;
        imm = {i[31:12], 12'h000};
        case (op)
            7'b0110111: begin ok = 1'b1; lui = 1'b1; regwrite = 1'b1; end
            7'b0010111: begin ok = 1'b1; auipc = 1'b1; regwrite = 1'b1; end
            7'b1101111: begin
                ok = 1'b1; jal = 1'b1; regwrite = 1'b1;
                imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b1100111: begin ok = f3 == 3'd0; jalr = 1'b1; regwrite = 1'b1; alusrc_imm = 1'b1; imm = imm_i; end
            7'b1100011: begin ok = f3[2:1] != 2'b01; br = 1'b1; imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'b0000011: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                memread = 1'b1; regwrite = 1'b1; alusrc_imm = 1'b1; imm = imm_i;
            end
            7'b0100011: begin ok = f3 < 3'd3; memwrite = 1'b1; alusrc_imm = 1'b1; imm = {{21{i[31]}}, i[30:25], i[11:7]}; end
            7'b0010011: begin
                regwrite = 1'b1; alusrc_imm = 1'b1; imm = imm_i;
                sra_sub = f3 == 3'd5 && f7 == 7'h20;
                ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            7'b0110011: begin
                regwrite = 1'b1;
                sra_sub = f7 == 7'h20;
                muldiv = MD_EN && f7 == 7'h01;
                ok = f7 == 7'h00 || (sra_sub && (f3 == 3'd0 || f3 == 3'd5)) || muldiv;
            end
            default: ;
        endcase
        if (!ok) begin
            regwrite = 1'b0;
            memread = 1'b0;
            memwrite = 1'b0;
            br = 1'b0;
            jal = 1'b0;
            jalr = 1'b0;
        end
        if (i[11:7] == 5'd0) regwrite = 1'b0;
    end
    always_comb state_nx = DU_flush ? RUN : (load && !ok) ? HALT : state;
    always_ff @(posedge clk) state <= rst ? RUN : state_nx;
    assign DU_halted = state == HALT;
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= IFQ_instr;
            pc_mem[wr_ptr] <= IFQ_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || DU_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            DU_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(load);
            DU_count <= DU_count + (AW+1)'(push) - (AW+1)'(load);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            DU_valid <= 1'b0;
            DU_pc <= '0;
            DU_rs1 <= '0;
            DU_rs2 <= '0;
            DU_rd <= '0;
            DU_imm <= '0;
            DU_aluop <= '0;
            {DU_sra_sub, DU_alusrc_imm, DU_memread, DU_memwrite, DU_br, DU_jal} <= '0;
            {DU_jalr, DU_lui, DU_auipc, DU_regwrite, DU_illegal, DU_muldiv} <= '0;
        end else if (DU_flush) begin
            DU_valid <= 1'b0;
        end else if (load) begin
            DU_valid <= 1'b1;
            DU_pc <= pc_mem[rd_ptr];
            DU_rs1 <= i[19:15];
            DU_rs2 <= i[24:20];
            DU_rd <= i[11:7];
            DU_imm <= imm;
            DU_aluop <= f3;
            {DU_sra_sub, DU_alusrc_imm, DU_memread, DU_memwrite, DU_br, DU_jal} <= {sra_sub, alusrc_imm, memread, memwrite, br, jal};
            {DU_jalr, DU_lui, DU_auipc, DU_regwrite, DU_illegal, DU_muldiv} <= {jalr, lui, auipc, regwrite, !ok, muldiv};
        end else if (EX_ready) begin
            DU_valid <= 1'b0;
        end
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, buffered RV32I decode stage between the instruction fetch queue (IFQ) and execute/dispatch (EX).
- Accepts {pc, instruction} pairs over a valid/ready handshake into a DEPTH-entry FIFO.
- Decodes the FIFO head into a full control/immediate bundle and presents it through a registered output with valid/ready.
- Adds flush, illegal-instruction detection and a HALT state; correctly separates SRAI/SUB from ADDI, and JAL from JALR.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
PC_W, 32, width of the PC carried with each instruction

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
IFQ_valid  input  1  instruction/pc offered
IFQ_ready  output  1  stage can accept (FIFO not full)
IFQ_instr  input  32  instruction word
IFQ_pc  input  PC_W  instruction address
DU_flush  input  1  discard all buffered/held instructions, leave HALT
EX_ready  input  1  consumer accepts current bundle
DU_valid  output  1  bundle valid
DU_pc  output  PC_W  pc of bundle
DU_rs1, DU_rs2, DU_rd  output  5 each  register fields
DU_imm  output  32  sign-extended immediate (U/J/B/S/I formats)
DU_aluop  output  3  funct3
DU_sra_sub  output  1  SUB/SRA/SRAI select
DU_alusrc_imm  output  1  ALU operand B = imm (OP-IMM, load, store, JALR)
DU_memread, DU_memwrite, DU_br, DU_jal, DU_jalr, DU_lui, DU_auipc  output  1 each  class flags
DU_regwrite  output  1  writes rd; forced 0 when rd==0
DU_illegal  output  1  instruction not decodable
DU_muldiv  output  1  RV32M op (0 unless MULDIV_EN)
DU_halted  output  1  FSM in HALT
DU_count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO pointers/count 0; DU_valid 0; every DU_* bundle output 0; FSM=RUN; IFQ_ready 1 on first cycle after reset.
- Push: IFQ_valid & IFQ_ready at edge. IFQ_ready = (count != DEPTH). No combinational path from EX_ready to IFQ_ready.
- Load: output register loads when FSM==RUN & count!=0 & (!DU_valid | EX_ready). Loading pops the FIFO head, decodes it and sets DU_valid=1.
- Retire: if DU_valid & EX_ready and no load occurs, DU_valid drops to 0. Bundle holds stable while DU_valid & !EX_ready.
- Latency: push at edge N gives DU_valid at edge N+1 when the stage is empty. Sustained throughput 1/cycle. Total capacity DEPTH+1.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Flush: DU_flush at an edge has priority over everything.
  - count, pointers and DU_valid go to 0; FSM=RUN.
  - A simultaneous push is dropped; a simultaneous EX_ready handshake still counts as consumed by EX.
- Decode (opcode = instr[6:0]); instr[1:0]!=11 is illegal.
  - LUI/AUIPC: U-imm.
  - JAL: J-imm, regwrite.
  - JALR: requires funct3==000; I-imm, regwrite, alusrc_imm.
  - BRANCH: requires funct3 not 010/011; B-imm.
  - LOAD: requires funct3 in {000,001,010,100,101}; I-imm, memread, regwrite.
  - STORE: requires funct3 in {000,001,010}; S-imm, memwrite.
  - OP-IMM: I-imm, regwrite. funct3 001 needs funct7==0. funct3 101 needs funct7 0000000 or 0100000, and sra_sub = (funct7==0100000). Other funct3: sra_sub=0.
  - OP: funct7 0000000 or 0100000. 0100000 is legal only with funct3 000/101, and then sra_sub=1.
  - Any other opcode or failed check: DU_illegal=1, and regwrite, memread, memwrite, br, jal, jalr all 0.
  - Unspecified fields: imm defaults to U-format; register fields are raw instruction bits.
- FSM:
  - RUN -> HALT at the edge an illegal bundle is loaded.
  - In HALT: no further loads; the illegal bundle is still presented and retired normally; pushes continue until full.
  - HALT -> RUN only on DU_flush. DU_halted = (FSM==HALT).

Optional Feature:
- Macro: DECODE_MULDIV_EN.
- Defined: OP with funct7==0000001 (any funct3) is legal; DU_muldiv=1, regwrite, sra_sub=0.
- Undefined: that encoding is illegal and DU_muldiv is tied 0.

Test Plan:
- Reset; push 0x00500093 (addi x1,x0,5) pc 0x0, EX_ready=1 -> next cycle DU_valid=1, rd=1, imm=0x5, regwrite=1, alusrc_imm=1, aluop=0, sra_sub=0.
- EX_ready=0; push 6 back-to-back -> 5 accepted, IFQ_ready=0 with DU_count=4; bundle stable. Raise EX_ready -> 5 bundles in order, one per cycle.
- Push 0xFE208EE3 (beq x1,x2,-4) -> br=1, imm=0xFFFFFFFC, regwrite=0. Push 0x00000033 (add x0,x0,x0) -> regwrite=0. Push 0x40105093 (srai x1,x0,1) -> sra_sub=1.
- Push 0xFFFFFFFF, then addi -> illegal bundle with DU_illegal=1 and DU_halted=1; addi stays queued (DU_count=1) until DU_flush, then count=0, halted=0.
- DU_flush with simultaneous IFQ_valid and 3 queued -> next cycle DU_count=0, DU_valid=0, pushed word never appears.
- Push 0x022081B3 (mul x3,x1,x2) -> with DECODE_MULDIV_EN: muldiv=1, regwrite=1, illegal=0; without it: illegal=1, HALT.
